service_packet_receiver: RTL and testbench
==========================================

# service_packet_receiver

Word-level receiver for the service protocol carried over SPI. It sits between the SPI slave word deserializer and the mil transmit ring buffer inside the mil/SPI converter. It parses the address/size/command header and decodes the FFA1/FFA3 escape words into typed payload words. It verifies the 16-bit checksum and reports a commit or abort pulse per packet, so that downstream storage can keep or discard what it has already written.

## Interface
- BLOCK_ADDR, 8'hAB, service address this instance answers to (upper byte of the first packet word)
- TIMEOUT, 16'd2000, maximum idle clk cycles between two words inside a packet

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- inData  in  16  received SPI word
- inValid  in  1  one-cycle strobe per received word; no backpressure
- outData  out  16  decoded payload word
- outServ  out  1  1 = WSERV word, 0 = WDATA word; qualified by outValid
- outValid  out  1  one-cycle strobe per decoded payload word
- pktStart  out  1  one-cycle pulse when an addressed header is accepted
- cmd  out  8  command byte of the current packet; held until the next pktStart
- pktOk  out  1  one-cycle pulse: the packet completed with the checksum correct
- pktErr  out  1  one-cycle pulse: the packet was aborted
- errCode  out  2  0 none, 1 checksum, 2 timeout, 3 escape framing; held until the next pktStart
- pktNum  out  16  trailing word-number field; valid from pktOk/pktErr until the next pktStart

## Operation
- Packet format: W0 = {addr, 8'hxx}; W1 = {size[7:0], cmd[7:0]}; then size payload words, with escape words counted in size; then checksum; then word number.
- Checksum is the modulo-2^16 sum of W0 through the last payload word, escape words included.
- Escapes:
  - 16'hFFA1 means the next word is emitted with outServ=1.
  - 16'hFFA3 means the next word is emitted as data verbatim.
  - Escape words themselves are never emitted.
  - Every other word is emitted as data.
- States:
  - IDLE: wait for W0. If inData[15:8]==BLOCK_ADDR go to HDR, otherwise go to SKIPHDR. The low byte of W0 is ignored.
  - HDR: latch size and cmd, pulse pktStart, and clear errCode. Go to PAYLOAD, or to CSUM if size==0.
  - PAYLOAD: decrement the remaining count on every word. A pending escape flag marks the next word. Go to CSUM when the count reaches 0.
  - CSUM: compare the word with the accumulated sum. On mismatch latch error 1. Go to NUM.
  - NUM: latch pktNum. Pulse pktOk if no error is latched, otherwise pulse pktErr. Go to IDLE.
  - SKIPHDR / SKIP: consume W1, then size+2 further words with no outputs and no pulses. Return to IDLE.
- An escape that is the last payload word (escape flag still set on entering CSUM) latches error 3. Error 3 has priority over error 1. Reporting is deferred to NUM so that framing stays aligned.
- Timeout:
  - The idle counter runs in every state except IDLE and is cleared by inValid.
  - On reaching TIMEOUT: pulse pktErr with errCode=2 and go to IDLE.
  - inValid in the same cycle as expiry wins and the word is processed normally.
  - In SKIP states a timeout returns to IDLE silently.

## Timing
- All outputs are registered and reset to 0. The state resets to IDLE and the sum and counters reset to 0.
- outValid, pktStart, pktOk and pktErr follow the causing inValid by exactly one clk.
- pktOk and pktErr are mutually exclusive and fire exactly once per addressed packet.
- Back-to-back words (inValid on consecutive cycles) are accepted at full rate.
- Reset mid-packet: no pktOk or pktErr is produced; downstream treats the open packet as discarded.

## Structure
- Shared package serviceProtocol holds:
  - the constants ESC_WSERV=16'hFFA1 and ESC_WDATA=16'hFFA3
  - the error code enum (ERR_NONE, ERR_CSUM, ERR_TIMEOUT, ERR_ESC)
  - the receiver state enum
- The timeout counter goes in a sub-module, service_word_timer (inputs: clear, enable; output: expired), for reuse by the transmitter side.

## Test plan
- Addressed packet: AB00, 06A2, FFA1, 0001, 0002, AB45, FFA3, FFA1, 5BCF, 0000.
  - Required: pktStart with cmd=A2.
  - Required: outputs (0001, serv=1), (0002, 0), (AB45, 0), (FFA1, 0).
  - Required: pktOk, errCode=0, pktNum=0000.
- Same packet with checksum 5BCE -> the same four payload words, then pktErr with errCode=1 and no pktOk.
- Packet addressed to AC to an AB instance, immediately followed by the valid AB packet.
  - Required: nothing during the AC packet.
  - Required: the AB packet is decoded exactly as in the first scenario.
- AB00, 03A2, 0001, then silence -> pktErr with errCode=2 exactly TIMEOUT+1 cycles after the last inValid; the next clean packet is accepted.
- AB00, 01A2, FFA1, checksum AC A2+FFA1 = 1AC43 -> AC43, 0000.
  - Required: no outValid.
  - Required: pktErr with errCode=3.
- rst pulse after the second payload word of the first packet, then a full resend of that packet -> no pulses before the reset; after the resend, the first scenario's output is reproduced exactly.

Source files
------------

// File: rtl/service_packet_receiver_pkg.sv
// Shared service-protocol definitions: escape words, error codes and receiver states.
// Used by both the receive path and the transmit side of the mil/SPI converter.
package serviceProtocol;

    localparam logic [15:0] ESC_WSERV = 16'hFFA1;
    localparam logic [15:0] ESC_WDATA = 16'hFFA3;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ESC     = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_NUM     = 3'd4,
        ST_SKIPHDR = 3'd5,
        ST_SKIP    = 3'd6
    } rx_state_t;

endpackage

// File: rtl/service_packet_receiver_if.sv
// Word-level bus between the SPI word deserializer, the packet receiver and the
// downstream ring buffer: received words in, decoded payload and packet status out.
interface service_packet_receiver_if;
    logic [15:0] inData;
    logic        inValid;
    logic [15:0] outData;
    logic        outServ;
    logic        outValid;
    logic        pktStart;
    logic [7:0]  cmd;
    logic        pktOk;
    logic        pktErr;
    logic [1:0]  errCode;
    logic [15:0] pktNum;

    modport slave (
        input  inData, inValid,
        output outData, outServ, outValid, pktStart, cmd, pktOk, pktErr, errCode, pktNum
    );

    modport master (
        output inData, inValid,
        input  outData, outServ, outValid, pktStart, cmd, pktOk, pktErr, errCode, pktNum
    );
endinterface

// File: rtl/service_packet_receiver_word_timer.sv
// Inter-word idle timer: counts enabled cycles without a word and flags the cycle
// in which the idle count reaches TIMEOUT. A word in that same cycle suppresses expiry.
module service_word_timer #(
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count_reg;

    // count_reg holds idle cycles already elapsed; the current idle cycle is the TIMEOUT-th
    assign expired = enable && !clear && (count_reg == TIMEOUT - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 16'd0;
        end else if (clear || !enable || expired) begin
            count_reg <= 16'd0;
        end else begin
            count_reg <= count_reg + 16'd1;
        end
    end

endmodule

// File: rtl/service_packet_receiver.sv
// Service packet receiver: parses header, decodes FFA1/FFA3 escapes, checks the
// 16-bit sum and reports one commit/abort pulse per addressed packet.
module service_packet_receiver
    import serviceProtocol::*;
#(
    parameter logic [7:0]  BLOCK_ADDR = 8'hAB,
    parameter logic [15:0] TIMEOUT    = 16'd2000
) (
    input  logic                      clk,
    input  logic                      rst,
    service_packet_receiver_if.slave  bus
);

    rx_state_t   state_reg;
    err_code_t   err_code_reg;
    logic [15:0] sum_reg;
    logic [7:0]  remain_reg;
    logic [8:0]  skip_reg;
    logic        esc_serv_reg;
    logic        esc_data_reg;
    logic [15:0] out_data_reg;
    logic        out_serv_reg;
    logic        out_valid_reg;
    logic        pkt_start_reg;
    logic [7:0]  cmd_reg;
    logic        pkt_ok_reg;
    logic        pkt_err_reg;
    logic [15:0] pkt_num_reg;
    logic        timer_expired;

    service_word_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.inValid),
        .enable  (state_reg != ST_IDLE),
        .expired (timer_expired)
    );

    assign bus.outData  = out_data_reg;
    assign bus.outServ  = out_serv_reg;
    assign bus.outValid = out_valid_reg;
    assign bus.pktStart = pkt_start_reg;
    assign bus.cmd      = cmd_reg;
    assign bus.pktOk    = pkt_ok_reg;
    assign bus.pktErr   = pkt_err_reg;
    assign bus.errCode  = err_code_reg;
    assign bus.pktNum   = pkt_num_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            err_code_reg  <= ERR_NONE;
            sum_reg       <= 16'd0;
            remain_reg    <= 8'd0;
            skip_reg      <= 9'd0;
            esc_serv_reg  <= 1'b0;
            esc_data_reg  <= 1'b0;
            out_data_reg  <= 16'd0;
            out_serv_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            pkt_start_reg <= 1'b0;
            cmd_reg       <= 8'd0;
            pkt_ok_reg    <= 1'b0;
            pkt_err_reg   <= 1'b0;
            pkt_num_reg   <= 16'd0;
        end else begin
            out_valid_reg <= 1'b0;
            pkt_start_reg <= 1'b0;
            pkt_ok_reg    <= 1'b0;
            pkt_err_reg   <= 1'b0;

            if (bus.inValid) begin
                case (state_reg)
                    ST_IDLE: begin
                        sum_reg   <= bus.inData;
                        state_reg <= (bus.inData[15:8] == BLOCK_ADDR) ? ST_HDR : ST_SKIPHDR;
                    end
                    ST_HDR: begin
                        remain_reg    <= bus.inData[15:8];
                        cmd_reg       <= bus.inData[7:0];
                        pkt_start_reg <= 1'b1;
                        err_code_reg  <= ERR_NONE;
                        sum_reg       <= sum_reg + bus.inData;
                        esc_serv_reg  <= 1'b0;
                        esc_data_reg  <= 1'b0;
                        state_reg     <= (bus.inData[15:8] == 8'd0) ? ST_CSUM : ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        sum_reg    <= sum_reg + bus.inData;
                        remain_reg <= remain_reg - 8'd1;
                        // A pending escape consumes the word unconditionally, even FFA1/FFA3
                        if (esc_serv_reg || esc_data_reg) begin
                            out_data_reg  <= bus.inData;
                            out_serv_reg  <= esc_serv_reg;
                            out_valid_reg <= 1'b1;
                            esc_serv_reg  <= 1'b0;
                            esc_data_reg  <= 1'b0;
                        end else if (bus.inData == ESC_WSERV) begin
                            esc_serv_reg <= 1'b1;
                        end else if (bus.inData == ESC_WDATA) begin
                            esc_data_reg <= 1'b1;
                        end else begin
                            out_data_reg  <= bus.inData;
                            out_serv_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                        if (remain_reg == 8'd1) begin
                            state_reg <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (esc_serv_reg || esc_data_reg) begin
                            err_code_reg <= ERR_ESC;
                        end else if (bus.inData != sum_reg) begin
                            err_code_reg <= ERR_CSUM;
                        end
                        state_reg <= ST_NUM;
                    end
                    ST_NUM: begin
                        pkt_num_reg <= bus.inData;
                        if (err_code_reg == ERR_NONE) begin
                            pkt_ok_reg <= 1'b1;
                        end else begin
                            pkt_err_reg <= 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                    ST_SKIPHDR: begin
                        // payload plus checksum plus word number still to come
                        skip_reg  <= {1'b0, bus.inData[15:8]} + 9'd2;
                        state_reg <= ST_SKIP;
                    end
                    ST_SKIP: begin
                        skip_reg <= skip_reg - 9'd1;
                        if (skip_reg == 9'd1) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end else if (timer_expired) begin
                if (state_reg != ST_SKIPHDR && state_reg != ST_SKIP) begin
                    pkt_err_reg  <= 1'b1;
                    err_code_reg <= ERR_TIMEOUT;
                end
                state_reg <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_service_packet_receiver.sv
// Scoreboard bench for service_packet_receiver: directed packets push expected
// events; a negedge monitor pops and compares each DUT output event.
module tb_service_packet_receiver;

    localparam logic [15:0] T = 16'd20;

    localparam int EV_OUT   = 0;
    localparam int EV_START = 1;
    localparam int EV_OK    = 2;
    localparam int EV_ERR   = 3;

    typedef struct {
        int          kind;
        logic [15:0] data;
        logic        serv;
        logic [1:0]  code;
        logic        chk_num;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    service_packet_receiver_if bus ();

    service_packet_receiver #(.BLOCK_ADDR(8'hAB), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic ev_t mk(int kind, logic [15:0] data, logic serv, logic [1:0] code, logic chk_num);
        ev_t e;
        e.kind = kind; e.data = data; e.serv = serv; e.code = code; e.chk_num = chk_num;
        return e;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic compare_event(input ev_t obs);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected event: kind=%0d data=%h serv=%0d code=%0d, expected none",
                     obs.kind, obs.data, obs.serv, obs.code);
        end else begin
            e = exp_q.pop_front();
            check("event kind", 16'(obs.kind), 16'(e.kind));
            if (e.kind == EV_OUT) begin
                check("outData", obs.data, e.data);
                check("outServ", {15'd0, obs.serv}, {15'd0, e.serv});
            end else if (e.kind == EV_START) begin
                check("cmd", obs.data, e.data);
            end else begin
                check("errCode", {14'd0, obs.code}, {14'd0, e.code});
                if (e.chk_num) check("pktNum", obs.data, e.data);
            end
            $display("event kind=%0d data=%h serv=%0d code=%0d", obs.kind, obs.data, obs.serv, obs.code);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.pktOk && bus.pktErr) begin
                total++;
                bad++;
                $display("FAIL ok_err_exclusive: got both 1 expected at most one");
            end
            if (bus.outValid) compare_event(mk(EV_OUT, bus.outData, bus.outServ, 2'd0, 1'b0));
            if (bus.pktStart) compare_event(mk(EV_START, {8'd0, bus.cmd}, 1'b0, 2'd0, 1'b0));
            if (bus.pktOk)    compare_event(mk(EV_OK, bus.pktNum, 1'b0, bus.errCode, 1'b0));
            if (bus.pktErr)   compare_event(mk(EV_ERR, bus.pktNum, 1'b0, bus.errCode, 1'b0));
        end
    end

    logic [15:0] good_pkt [10] = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002,
                                   16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5BCF, 16'h0000};

    task automatic send(input logic [15:0] w);
        bus.inData  = w;
        bus.inValid = 1'b1;
        @(negedge clk);
        bus.inValid = 1'b0;
    endtask

    task automatic push_good_payload();
        exp_q.push_back(mk(EV_START, 16'h00A2, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(EV_OUT, 16'h0001, 1'b1, 2'd0, 1'b0));
        exp_q.push_back(mk(EV_OUT, 16'h0002, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(EV_OUT, 16'hAB45, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(EV_OUT, 16'hFFA1, 1'b0, 2'd0, 1'b0));
    endtask

    task automatic send_good();
        push_good_payload();
        exp_q.push_back(mk(EV_OK, 16'h0000, 1'b0, 2'd0, 1'b1));
        for (int i = 0; i < 10; i++) send(good_pkt[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.inData  = 16'd0;
        bus.inValid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outValid", {15'd0, bus.outValid}, 16'd0);
        check("reset pktStart", {15'd0, bus.pktStart}, 16'd0);
        check("reset pktOk",    {15'd0, bus.pktOk},    16'd0);
        check("reset pktErr",   {15'd0, bus.pktErr},   16'd0);
        check("reset errCode",  {14'd0, bus.errCode},  16'd0);
        check("reset cmd",      {8'd0, bus.cmd},       16'd0);
        check("reset pktNum",   bus.pktNum,            16'd0);
        check("reset outData",  bus.outData,           16'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: clean addressed packet
        send_good();
        repeat (3) @(negedge clk);

        // 2: same packet with a wrong checksum
        push_good_payload();
        exp_q.push_back(mk(EV_ERR, 16'h0000, 1'b0, 2'd1, 1'b1));
        for (int i = 0; i < 8; i++) send(good_pkt[i]);
        send(16'h5BCE);
        send(16'h0000);
        repeat (3) @(negedge clk);

        // 3: packet for another address, immediately followed by ours
        send(16'hAC00);
        for (int i = 1; i < 10; i++) send(good_pkt[i]);
        send_good();
        repeat (3) @(negedge clk);

        // 4: timeout mid-payload, then recovery
        exp_q.push_back(mk(EV_START, 16'h00A2, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(EV_OUT, 16'h0001, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(EV_ERR, 16'h0000, 1'b0, 2'd2, 1'b0));
        send(16'hAB00);
        send(16'h03A2);
        send(16'h0001);
        n = 0;
        while (!bus.pktErr && n < 3 * int'(T)) begin
            @(negedge clk);
            n++;
        end
        check("timeout latency", 16'(n), T);
        repeat (3) @(negedge clk);
        send_good();
        repeat (3) @(negedge clk);

        // 5: escape as the last payload word
        exp_q.push_back(mk(EV_START, 16'h00A2, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(EV_ERR, 16'h0000, 1'b0, 2'd3, 1'b1));
        send(16'hAB00);
        send(16'h01A2);
        send(16'hFFA1);
        send(16'hAC43);
        send(16'h0000);
        repeat (3) @(negedge clk);

        // 6: reset after the second payload word, then full resend
        exp_q.push_back(mk(EV_START, 16'h00A2, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(EV_OUT, 16'h0001, 1'b1, 2'd0, 1'b0));
        for (int i = 0; i < 4; i++) send(good_pkt[i]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-reset outValid", {15'd0, bus.outValid}, 16'd0);
        check("mid-reset pktErr",   {15'd0, bus.pktErr},   16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_good();
        repeat (5) @(negedge clk);

        check("scoreboard drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
